// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide sequencer.
// Holds the op and state enums plus the signed-magnitude helper.
package muldiv_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MUL  = 3'd1,
      DIV  = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } md_state_e;

   localparam int DIV_ITERS       = 32;
   localparam int MULT_CYCLES_DEF = 4;

   // Magnitude of v, treating it as two's complement only when sgn is set.
   function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/divu_core.sv
// Iterative 32-bit unsigned restoring divider, one quotient bit per step.
// load captures the operands; each step shifts one dividend bit into the remainder.
module divu_core (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvs_q, dvs_d;
   logic [32:0] shifted;

   always_comb begin
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      shifted = {rem_q, quo_q[31]};
      if (load) begin
         rem_d = '0;
         quo_d = dividend;
         dvs_d = divisor;
      end else if (step) begin
         // Partial remainder stays below the divisor, so 32 bits always hold the result.
         if (shifted >= {1'b0, dvs_q}) begin
            rem_d = shifted[31:0] - dvs_q;
            quo_d = {quo_q[30:0], 1'b1};
         end else begin
            rem_d = shifted[31:0];
            quo_d = {quo_q[30:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_d;
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner: sequences multi-cycle MULT/MULTU/DIV/DIVU, applies MTHI/MTLO, stalls readers.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO write here
// MUL   | multiply latency countdown, writes HI/LO at terminal count
// DIV   | 32 restoring steps on operand magnitudes
// FIX   | apply quotient/remainder signs and write HI/LO
// DONE  | divide-by-zero writeback
module hilo_muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        flush,
   input  logic        rd_req,
   output logic        busy,
   output logic        stall,
   output logic        done,
   output logic        div_zero,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_e   state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic        busy_q, busy_d, done_q, done_d, dz_q, dz_d;
   logic        mul_sgn_q, mul_sgn_d, qneg_q, qneg_d, rneg_q, rneg_d;

   md_op_e      op_e;
   logic        accept, div_sgn, div_load, div_step;
   logic [31:0] div_dvd, div_dvs, div_quo, div_rem;
   logic [63:0] mul_a, mul_b, prod;

   assign op_e    = md_op_e'(op);
   assign accept  = start & ~busy_q & ~flush;
   assign div_sgn = (op_e == MD_DIV);
   assign div_dvd = abs32(rs_data, div_sgn);
   assign div_dvs = abs32(rt_data, div_sgn);

   // Sign/zero extension to 64 bits makes the low 64 product bits exact for both signednesses.
   assign mul_a = {{32{mul_sgn_q & a_q[31]}}, a_q};
   assign mul_b = {{32{mul_sgn_q & b_q[31]}}, b_q};
   assign prod  = mul_a * mul_b;

   divu_core u_divu (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (div_load),
      .step      (div_step),
      .dividend  (div_dvd),
      .divisor   (div_dvs),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      a_d       = a_q;
      b_d       = b_q;
      done_d    = 1'b0;
      dz_d      = dz_q;
      mul_sgn_d = mul_sgn_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      div_load  = 1'b0;
      div_step  = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               case (op_e)
                  MD_MULT, MD_MULTU: begin
                     state_d   = MUL;
                     cnt_d     = 5'(MULT_CYCLES - 1);
                     a_d       = rs_data;
                     b_d       = rt_data;
                     mul_sgn_d = (op_e == MD_MULT);
                  end
                  MD_DIV, MD_DIVU: begin
                     a_d    = rs_data;
                     qneg_d = div_sgn & (rs_data[31] ^ rt_data[31]);
                     rneg_d = div_sgn & rs_data[31];
                     if (rt_data == 32'd0) begin
                        state_d = DONE;
                     end else begin
                        state_d  = DIV;
                        cnt_d    = 5'(DIV_ITERS - 1);
                        div_load = 1'b1;
                     end
                  end
                  MD_MTHI: hi_d = rs_data;
                  MD_MTLO: lo_d = rs_data;
                  default: ;
               endcase
            end
         end
         MUL: begin
            if (cnt_q == 5'd0) begin
               hi_d    = prod[63:32];
               lo_d    = prod[31:0];
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         DIV: begin
            div_step = 1'b1;
            if (cnt_q == 5'd0) state_d = FIX;
            else               cnt_d   = cnt_q - 5'd1;
         end
         FIX: begin
            lo_d    = qneg_q ? (~div_quo + 32'd1) : div_quo;
            hi_d    = rneg_q ? (~div_rem + 32'd1) : div_rem;
            dz_d    = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         DONE: begin
            lo_d    = '1;
            hi_d    = a_q;
            dz_d    = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Abort discards any pending writeback, including one due on this edge.
      if (flush) begin
         state_d = IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
         dz_d    = dz_q;
         done_d  = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
         mul_sgn_q <= 1'b0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         a_q       <= a_d;
         b_q       <= b_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dz_q      <= dz_d;
         mul_sgn_q <= mul_sgn_d;
         qneg_q    <= qneg_d;
         rneg_q    <= rneg_d;
      end
   end

   // Covering the accept cycle keeps a back-to-back MFHI/MFLO from reading stale HI/LO.
   assign stall    = rd_req & (busy_q | (start & ~op[2]));
   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = dz_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule
